fp_add_unit: RTL and testbench

Multi-cycle IEEE-754 single-precision adder that executes the add operations flagged by the FP instruction decoder. It sits in the FP datapath between the FP register-file read ports and the FP register-file write port. It accepts one operation at a time on a start pulse, runs a fixed-latency unpack/align/add/normalize/pack sequence, and issues a one-cycle write-back request to the FP register file. It asserts `busy` so the pipeline stalls while an operation is in flight.

---
 rtl/fp_pkg.sv | 48 ++++
 rtl/fp_add_unit_lzc24.sv | 16 +
 rtl/fp_add_unit.sv | 180 ++++++++++++++++++
 tb/tb_fp_add_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared types and constants for the single-precision FP add unit.
// Holds the sequencer state encoding plus the operand unpack/classify helpers.
package fp_pkg;

  localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;
  localparam int EXP_W     = 8;
  localparam int MAN_W     = 23;
  localparam int EXP_MAX   = 255;
  localparam int MAX_SHIFT = 26;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_ALIGN,
    ST_ADD,
    ST_NORM,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   man;
  } fp_unp_t;

  typedef struct packed {
    logic nan;
    logic inf;
  } fp_cls_t;

  // Exponent 0 covers zeros and denormals; both flush to a signed zero.
  function automatic fp_unp_t fp_unpack(input logic [31:0] x);
    fp_unp_t u;
    u.sign = x[31];
    u.exp  = x[30:23];
    u.man  = (x[30:23] == '0) ? '0 : {1'b1, x[22:0]};
    return u;
  endfunction

  function automatic fp_cls_t fp_classify(input logic [31:0] x);
    fp_cls_t c;
    c.nan = (x[30:23] == 8'hFF) && (x[22:0] != '0);
    c.inf = (x[30:23] == 8'hFF) && (x[22:0] == '0);
    return c;
  endfunction

endpackage

// File: rtl/fp_add_unit_lzc24.sv
// Combinational leading-zero counter over a 24-bit mantissa.
// An all-zero input reports 24.
module fp_add_unit_lzc24 (
  input  logic [23:0] value,
  output logic [4:0]  count
);

  // Ascending scan so the highest set bit has the final say.
  always_comb begin
    count = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (value[i]) count = 5'(23 - i);
    end
  end

endmodule

// File: rtl/fp_add_unit.sv
// Multi-cycle IEEE-754 single-precision adder with truncation and flush-to-zero.
// Sequence IDLE->UNPACK->ALIGN->ADD->NORM->DONE; one write-back pulse per operation.
module fp_add_unit
  import fp_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       fs,
  input  logic [31:0]       ft,
  input  logic [REG_AW-1:0] fd,
  output logic              busy,
  output logic              done,
  output logic [31:0]       result,
  output logic              wr_en,
  output logic [REG_AW-1:0] wr_addr
);

  state_t       state;
  logic [31:0]  fs_q, ft_q;
  fp_unp_t      ua, ub;
  logic         spec_vld;
  logic [31:0]  spec_val;
  logic         big_s, eff_sub;
  logic [7:0]   big_e;
  logic [23:0]  big_m, sm_m;
  logic [24:0]  sum;
  logic         sum_s;
  logic [7:0]   sum_e;

  // Unpack stage: split operands and resolve special-value outcomes early.
  fp_unp_t ua_c, ub_c;
  fp_cls_t ca_c, cb_c;
  logic        spec_vld_c;
  logic [31:0] spec_val_c;

  always_comb begin
    ua_c = fp_unpack(fs_q);
    ub_c = fp_unpack(ft_q);
    ca_c = fp_classify(fs_q);
    cb_c = fp_classify(ft_q);
    spec_vld_c = 1'b1;
    spec_val_c = FP_QNAN;
    if (ca_c.nan || cb_c.nan) begin
      spec_val_c = FP_QNAN;
    end else if (ca_c.inf && cb_c.inf) begin
      spec_val_c = (ua_c.sign != ub_c.sign) ? FP_QNAN : (FP_POS_INF | {ua_c.sign, 31'd0});
    end else if (ca_c.inf) begin
      spec_val_c = FP_POS_INF | {ua_c.sign, 31'd0};
    end else if (cb_c.inf) begin
      spec_val_c = FP_POS_INF | {ub_c.sign, 31'd0};
    end else if (ua_c.man == '0 && ub_c.man == '0) begin
      spec_val_c = {ua_c.sign & ub_c.sign, 31'd0};
    end else begin
      spec_vld_c = 1'b0;
    end
  end

  // Align stage: larger magnitude becomes A; the smaller mantissa is shifted down.
  logic        a_ge_b;
  fp_unp_t     big_c, small_c;
  logic [7:0]  diff_c;
  logic [23:0] sm_m_c;

  always_comb begin
    a_ge_b  = {ua.exp, ua.man} >= {ub.exp, ub.man};
    big_c   = a_ge_b ? ua : ub;
    small_c = a_ge_b ? ub : ua;
    diff_c  = big_c.exp - small_c.exp;
    sm_m_c  = (diff_c >= 8'(MAX_SHIFT)) ? '0 : (small_c.man >> diff_c);
  end

  // Add stage: the ordering guarantees the difference is never negative.
  logic [24:0] sum_c;
  assign sum_c = eff_sub ? ({1'b0, big_m} - {1'b0, sm_m}) : ({1'b0, big_m} + {1'b0, sm_m});

  // Normalize stage.
  logic [4:0]        lzc;
  logic signed [9:0] e_n;
  logic [22:0]       m_n;
  logic [31:0]       norm_res;

  fp_add_unit_lzc24 u_lzc (
    .value (sum[23:0]),
    .count (lzc)
  );

  always_comb begin
    if (sum[24]) begin
      m_n = sum[23:1];
      e_n = $signed({2'b00, sum_e}) + 10'sd1;
    end else begin
      m_n = sum[22:0] << lzc;
      e_n = $signed({2'b00, sum_e}) - $signed({5'd0, lzc});
    end
    if (spec_vld)
      norm_res = spec_val;
    else if (sum == '0)
      norm_res = '0;
    else if (e_n >= 10'(EXP_MAX))
      norm_res = FP_POS_INF | {sum_s, 31'd0};
    else if (e_n <= 10'sd0)
      norm_res = '0;
    else
      norm_res = {sum_s, e_n[7:0], m_n};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      wr_addr  <= '0;
      fs_q     <= '0;
      ft_q     <= '0;
      ua       <= '0;
      ub       <= '0;
      spec_vld <= 1'b0;
      spec_val <= '0;
      big_s    <= 1'b0;
      eff_sub  <= 1'b0;
      big_e    <= '0;
      big_m    <= '0;
      sm_m     <= '0;
      sum      <= '0;
      sum_s    <= 1'b0;
      sum_e    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            fs_q    <= fs;
            ft_q    <= ft;
            wr_addr <= fd;
            busy    <= 1'b1;
            state   <= ST_UNPACK;
          end
        end
        ST_UNPACK: begin
          ua       <= ua_c;
          ub       <= ub_c;
          spec_vld <= spec_vld_c;
          spec_val <= spec_val_c;
          state    <= ST_ALIGN;
        end
        ST_ALIGN: begin
          big_s   <= big_c.sign;
          big_e   <= big_c.exp;
          big_m   <= big_c.man;
          sm_m    <= sm_m_c;
          eff_sub <= ua.sign ^ ub.sign;
          state   <= ST_ADD;
        end
        ST_ADD: begin
          sum   <= sum_c;
          sum_s <= big_s;
          sum_e <= big_e;
          state <= ST_NORM;
        end
        ST_NORM: begin
          result <= norm_res;
          done   <= 1'b1;
          state  <= ST_DONE;
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign wr_en = done;

endmodule

// File: tb/tb_fp_add_unit.sv
// Directed-vector bench for fp_add_unit; edge 0 is the edge after which start is raised.
// Covers arithmetic, specials, overflow/underflow, busy drops, back-to-back and reset abort.
module tb_fp_add_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] fs, ft;
  logic [4:0]  fd;
  logic        busy, done, wr_en;
  logic [31:0] result;
  logic [4:0]  wr_addr;

  int n_cmp = 0;
  int n_bad = 0;

  fp_add_unit #(.REG_AW(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .fs      (fs),
    .ft      (ft),
    .fd      (fd),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .wr_en   (wr_en),
    .wr_addr (wr_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  d;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] d,
                        input logic [31:0] r, input string nm);
    int done_edge;
    int wr_cnt;
    done_edge = -1;
    wr_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; fs = a; ft = b; fd = d;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk); #1;
      if (e == 1) begin
        start = 1'b0;
        chk({nm, " busy_after_accept"}, 32'(busy), 32'd1);
      end
      if (wr_en) begin
        wr_cnt++;
        if (done_edge < 0) begin
          done_edge = e;
          chk({nm, " result"}, result, r);
          chk({nm, " wr_addr"}, 32'(wr_addr), 32'(d));
          chk({nm, " done_eq_wr_en"}, 32'(done), 32'd1);
          chk({nm, " busy_in_done"}, 32'(busy), 32'd1);
        end
      end
    end
    chk({nm, " latency_edge"}, 32'(done_edge), 32'd5);
    chk({nm, " wr_en_count"}, 32'(wr_cnt), 32'd1);
    chk({nm, " result_hold"}, result, r);
    chk({nm, " busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int wr_cnt;
    int e_first;
    int e_second;

    rst = 1'b1; start = 1'b0; fs = '0; ft = '0; fd = '0;

    vecs.push_back('{32'h3F800000, 32'h40000000, 5'd3,  32'h40400000});
    vecs.push_back('{32'h40000000, 32'h3F800000, 5'd1,  32'h40400000});
    vecs.push_back('{32'h3F800000, 32'hBF400000, 5'd2,  32'h3E800000});
    vecs.push_back('{32'h3FC00000, 32'hBFC00000, 5'd4,  32'h00000000});
    vecs.push_back('{32'h7F800000, 32'hFF800000, 5'd5,  32'h7FC00000});
    vecs.push_back('{32'h7FC00001, 32'h3F800000, 5'd6,  32'h7FC00000});
    vecs.push_back('{32'hFF800000, 32'h40000000, 5'd7,  32'hFF800000});
    vecs.push_back('{32'h7F7FFFFF, 32'h7F7FFFFF, 5'd8,  32'h7F800000});
    vecs.push_back('{32'h00000001, 32'h3F800000, 5'd9,  32'h3F800000});
    vecs.push_back('{32'hBF800000, 32'hC0000000, 5'd10, 32'hC0400000});
    vecs.push_back('{32'h80000000, 32'h80000000, 5'd11, 32'h80000000});
    vecs.push_back('{32'h80000000, 32'h00000000, 5'd12, 32'h00000000});
    vecs.push_back('{32'h4B800000, 32'h3F800000, 5'd13, 32'h4B800000});
    vecs.push_back('{32'h4C800000, 32'h3F800000, 5'd14, 32'h4C800000});
    vecs.push_back('{32'h3F800001, 32'h3F800000, 5'd15, 32'h40000000});
    vecs.push_back('{32'h00C00000, 32'h80800000, 5'd16, 32'h00000000});
    vecs.push_back('{32'h7F800000, 32'h7F800000, 5'd17, 32'h7F800000});
    vecs.push_back('{32'h3F800000, 32'h7FC00000, 5'd18, 32'h7FC00000});
    vecs.push_back('{32'hFF7FFFFF, 32'hFF7FFFFF, 5'd19, 32'hFF800000});
    vecs.push_back('{32'h3F800000, 32'hC0000000, 5'd31, 32'hBF800000});

    #12;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset wr_en", 32'(wr_en), 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset wr_addr", 32'(wr_addr), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].r, $sformatf("vec%0d", i));
    end

    // Starts during an operation are dropped; a start in the IDLE cycle after DONE is taken.
    wr_cnt = 0; e_first = -1; e_second = -1;
    @(posedge clk); #1;
    start = 1'b1; fs = 32'h3F800000; ft = 32'h40000000; fd = 5'd3;
    for (int e = 1; e <= 14; e++) begin
      @(posedge clk); #1;
      if (wr_en) begin
        wr_cnt++;
        if (e_first < 0) begin
          e_first = e;
          chk("busyseq first result", result, 32'h40400000);
          chk("busyseq first wr_addr", 32'(wr_addr), 32'd3);
        end else if (e_second < 0) begin
          e_second = e;
          chk("busyseq second result", result, 32'h40800000);
          chk("busyseq second wr_addr", 32'(wr_addr), 32'd7);
        end
      end
      case (e)
        1: start = 1'b0;
        2: begin start = 1'b1; fs = 32'h41000000; ft = 32'h41000000; fd = 5'd9; end
        3: start = 1'b0;
        5: begin start = 1'b1; fs = 32'h41000000; ft = 32'h41000000; fd = 5'd9; end
        6: begin fs = 32'h40000000; ft = 32'h40000000; fd = 5'd7; end
        7: start = 1'b0;
        default: ;
      endcase
    end
    chk("busyseq wr_en_count", 32'(wr_cnt), 32'd2);
    chk("busyseq first edge", 32'(e_first), 32'd5);
    chk("busyseq second edge", 32'(e_second), 32'd11);

    // Reset asserted while the operation sits in ALIGN.
    @(posedge clk); #1;
    start = 1'b1; fs = 32'h3F800000; ft = 32'h40000000; fd = 5'd5;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort wr_en", 32'(wr_en), 32'd0);
    chk("abort result", result, 32'd0);
    chk("abort wr_addr", 32'(wr_addr), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    wr_cnt = 0;
    for (int e = 0; e < 10; e++) begin
      @(posedge clk); #1;
      if (wr_en) wr_cnt++;
    end
    chk("abort no_wr_en", 32'(wr_cnt), 32'd0);
    run_op(32'h40400000, 32'h3F800000, 5'd21, 32'h40800000, "after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
